// File: rtl/cpu.sv
// Five-stage MIPS-subset pipeline (IF, ID, EX, MEM, WB) with on-chip memories and register file.
// An instruction fetched at edge N writes back at edge N+4. Hazards stall IF/ID; a taken beq or a j flushes one slot.

module PC (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n)    pc_o <= 32'd0;
        else if (en_i) pc_o <= pc_i;
endmodule

module Instruction_Memory (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [7:0]  addr_i,
    output logic [31:0] instr_o
);
    logic [31:0] memory [0:255];
    // Loader write port; the core ties it off and only fetches.
    always_ff @(posedge clk_i)
        if (we_i) memory[wa_i] <= wd_i;
    assign instr_o = memory[addr_i];
endmodule

module Registers (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] register [0:31];
    always_ff @(posedge clk_i)
        if (we_i && wa_i != 5'd0) register[wa_i] <= wd_i;
    // Same-cycle write is bypassed to the readers so ID never sees a stale value.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : register[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : register[ra2_i];
endmodule

module Data_Memory (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_o
);
    logic [7:0] memory [0:31];
    always_ff @(posedge clk_i)
        if (we_i) begin
            memory[{addr_i, 2'd0}] <= wd_i[7:0];
            memory[{addr_i, 2'd1}] <= wd_i[15:8];
            memory[{addr_i, 2'd2}] <= wd_i[23:16];
            memory[{addr_i, 2'd3}] <= wd_i[31:24];
        end
    assign rd_o = {memory[{addr_i, 2'd3}], memory[{addr_i, 2'd2}],
                   memory[{addr_i, 2'd1}], memory[{addr_i, 2'd0}]};
endmodule

module Control (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic       Jump_o,
    output logic       Branch_o,
    output logic       regwrite_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       alusrc_o,
    output logic       regdst_o,
    output logic [2:0] aluop_o
);
    always_comb begin
        Jump_o = 1'b0; Branch_o = 1'b0; regwrite_o = 1'b0; memread_o = 1'b0;
        memwrite_o = 1'b0; alusrc_o = 1'b0; regdst_o = 1'b0; aluop_o = 3'd0;
        case (op_i)
            6'h00: begin
                regdst_o = 1'b1;
                case (funct_i)
                    6'h20: begin regwrite_o = 1'b1; aluop_o = 3'd0; end
                    6'h22: begin regwrite_o = 1'b1; aluop_o = 3'd1; end
                    6'h24: begin regwrite_o = 1'b1; aluop_o = 3'd2; end
                    6'h25: begin regwrite_o = 1'b1; aluop_o = 3'd3; end
                    6'h18: begin regwrite_o = 1'b1; aluop_o = 3'd4; end
                    default: ;
                endcase
            end
            6'h08: begin regwrite_o = 1'b1; alusrc_o = 1'b1; end
            6'h23: begin regwrite_o = 1'b1; alusrc_o = 1'b1; memread_o = 1'b1; end
            6'h2B: begin memwrite_o = 1'b1; alusrc_o = 1'b1; end
            6'h04: Branch_o = 1'b1;
            6'h02: Jump_o = 1'b1;
            default: ;
        endcase
    end
endmodule

module HDU (
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_branch_i,
    input  logic       ex_rw_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_dst_i,
    input  logic       mem_rw_i,
    input  logic       mem_memread_i,
    input  logic [4:0] mem_dst_i,
    output logic       mux8_o,
    output logic       brhaz_o
);
    logic ex_hit, mem_hit;
    assign ex_hit  = ex_rw_i && (ex_dst_i == id_rs_i || ex_dst_i == id_rt_i);
    assign mem_hit = mem_rw_i && mem_memread_i && (mem_dst_i == id_rs_i || mem_dst_i == id_rt_i);
    // beq compares in ID: wait while its operand is still in EX, or is a load in MEM.
    assign brhaz_o = id_branch_i && (ex_hit || mem_hit);
    assign mux8_o  = brhaz_o || (ex_memread_i && ex_hit);
endmodule

module OR_Flush (
    input  logic a_i,
    input  logic b_i,
    output logic or_o
);
    assign or_o = a_i | b_i;
endmodule

module cpu (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    logic [31:0] pc, pc4, pc_next, if_instr, ifid_instr, ifid_pc4;
    logic        jump, branch, c_rw, c_mr, c_mw, c_src, c_dst, stall, brhaz, taken, flush;
    logic [2:0]  c_alu;
    logic [4:0]  rs, rt, id_dst;
    logic [31:0] rd1, rd2, imm, bra, brb, br_target;
    logic        idex_rw, idex_mr, idex_mw, idex_src;
    logic [2:0]  idex_alu;
    logic [4:0]  idex_rs, idex_rt, idex_dst;
    logic [31:0] idex_a, idex_b, idex_imm, fa, fb, alu_b, alu_y;
    logic        exmem_rw, exmem_mr, exmem_mw, memwb_rw;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_alu, exmem_st, ld_data, memwb_wd;

    assign pc4     = pc + 32'd4;
    assign pc_next = jump  ? {ifid_pc4[31:28], ifid_instr[25:0], 2'b00} :
                     taken ? br_target : pc4;

    PC PC (.clk_i(clk_i), .rst_n(rst_i), .en_i(flush || (start_i && !stall)),
           .pc_i(pc_next), .pc_o(pc));
    Instruction_Memory Instruction_Memory (.clk_i(clk_i), .we_i(1'b0), .wa_i(8'd0), .wd_i(32'd0),
                                           .addr_i(pc[9:2]), .instr_o(if_instr));

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            ifid_instr <= 32'd0;
            ifid_pc4   <= 32'd0;
        end else if (flush) begin
            ifid_instr <= 32'd0;
        end else if (!stall) begin
            // With start_i low nothing new is fetched; NOPs drain the pipe.
            ifid_instr <= start_i ? if_instr : 32'd0;
            ifid_pc4   <= pc4;
        end

    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];
    assign imm    = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    assign id_dst = c_dst ? ifid_instr[15:11] : rt;
    assign br_target = ifid_pc4 + {imm[29:0], 2'b00};

    Control Control (.op_i(ifid_instr[31:26]), .funct_i(ifid_instr[5:0]), .Jump_o(jump),
                     .Branch_o(branch), .regwrite_o(c_rw), .memread_o(c_mr), .memwrite_o(c_mw),
                     .alusrc_o(c_src), .regdst_o(c_dst), .aluop_o(c_alu));
    Registers Registers (.clk_i(clk_i), .we_i(memwb_rw), .wa_i(memwb_dst), .wd_i(memwb_wd),
                         .ra1_i(rs), .ra2_i(rt), .rd1_o(rd1), .rd2_o(rd2));
    HDU HDU (.id_rs_i(rs), .id_rt_i(rt), .id_branch_i(branch), .ex_rw_i(idex_rw),
             .ex_memread_i(idex_mr), .ex_dst_i(idex_dst), .mem_rw_i(exmem_rw),
             .mem_memread_i(exmem_mr), .mem_dst_i(exmem_dst), .mux8_o(stall), .brhaz_o(brhaz));

    assign bra   = (exmem_rw && !exmem_mr && exmem_dst == rs) ? exmem_alu : rd1;
    assign brb   = (exmem_rw && !exmem_mr && exmem_dst == rt) ? exmem_alu : rd2;
    assign taken = branch && !brhaz && (bra == brb);

    OR_Flush OR_Flush (.a_i(jump), .b_i(taken), .or_o(flush));

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            {idex_rw, idex_mr, idex_mw, idex_src, idex_alu} <= '0;
            {idex_rs, idex_rt, idex_dst} <= '0;
            {idex_a, idex_b, idex_imm}   <= '0;
        end else begin
            idex_rw  <= c_rw && id_dst != 5'd0 && !stall;
            idex_mr  <= c_mr && !stall;
            idex_mw  <= c_mw && !stall;
            idex_src <= c_src;
            idex_alu <= c_alu;
            idex_rs  <= rs;
            idex_rt  <= rt;
            idex_dst <= id_dst;
            idex_a   <= rd1;
            idex_b   <= rd2;
            idex_imm <= imm;
        end

    assign fa = (exmem_rw && exmem_dst == idex_rs) ? exmem_alu :
                (memwb_rw && memwb_dst == idex_rs) ? memwb_wd : idex_a;
    assign fb = (exmem_rw && exmem_dst == idex_rt) ? exmem_alu :
                (memwb_rw && memwb_dst == idex_rt) ? memwb_wd : idex_b;
    assign alu_b = idex_src ? idex_imm : fb;

    always_comb begin
        alu_y = fa + alu_b;
        case (idex_alu)
            3'd1:    alu_y = fa - alu_b;
            3'd2:    alu_y = fa & alu_b;
            3'd3:    alu_y = fa | alu_b;
            3'd4:    alu_y = fa * alu_b;
            default: alu_y = fa + alu_b;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            {exmem_rw, exmem_mr, exmem_mw, exmem_dst} <= '0;
            {exmem_alu, exmem_st} <= '0;
        end else begin
            exmem_rw  <= idex_rw;
            exmem_mr  <= idex_mr;
            exmem_mw  <= idex_mw;
            exmem_dst <= idex_dst;
            exmem_alu <= alu_y;
            exmem_st  <= fb;
        end

    Data_Memory Data_Memory (.clk_i(clk_i), .we_i(exmem_mw), .addr_i(exmem_alu[4:2]),
                             .wd_i(exmem_st), .rd_o(ld_data));

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            memwb_rw  <= 1'b0;
            memwb_dst <= 5'd0;
            memwb_wd  <= 32'd0;
        end else begin
            memwb_rw  <= exmem_rw;
            memwb_dst <= exmem_dst;
            memwb_wd  <= exmem_mr ? ld_data : exmem_alu;
        end
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: preloads programs, scoreboards register-file writebacks in program order,
// then checks final architectural state, PC trace and stall/flush counts.
module tb_cpu;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0;
    always #5 clk_i = ~clk_i;

    cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

    typedef struct { logic [4:0] r; logic [31:0] v; } wr_t;
    wr_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    int          flushes = 0;
    logic [31:0] pcs [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] v);
        wr_t e;
        e.r = r;
        e.v = v;
        sbq.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            stalls  = 0;
            flushes = 0;
        end else begin
            if (dut.HDU.mux8_o)    stalls++;
            if (dut.OR_Flush.or_o) flushes++;
            if (dut.Registers.we_i) begin
                chk("sb_pending", {31'd0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0) begin
                    wr_t e;
                    e = sbq.pop_front();
                    chk("wb_reg", {27'd0, dut.Registers.wa_i}, {27'd0, e.r});
                    chk("wb_val", dut.Registers.wd_i, e.v);
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i]  = 32'd0;
            dut.Data_Memory.memory[i] = 8'd0;
        end
        sbq.delete();
    endtask

    task automatic begin_test();
        rst_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_mem();
    endtask

    task automatic run(input int n);
        rst_i = 1'b1;
        start_i = 1'b1;
        #1 pcs[0] = dut.PC.pc_o;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            #1 pcs[k] = dut.PC.pc_o;
        end
        chk("sb_empty", sbq.size(), 32'd0);
    endtask

    function automatic logic [31:0] reg_of(input int r);
        return dut.Registers.register[r];
    endfunction

    initial begin
        // Reset/start with the ALU-forwarding program.
        clear_mem();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
        dut.Instruction_Memory.memory[2] = enc_r(5'd8, 5'd9, 5'd10, 6'h18);
        dut.Instruction_Memory.memory[3] = enc_r(5'd9, 5'd10, 5'd11, 6'h22);
        expect_wr(5'd8, 32'd5);
        expect_wr(5'd9, 32'd8);
        expect_wr(5'd10, 32'd40);
        expect_wr(5'd11, 32'hFFFF_FFE0);
        #11;
        chk("rst_pc", dut.PC.pc_o, 32'd0);
        chk("rst_mux8", {31'd0, dut.HDU.mux8_o}, 32'd0);
        chk("rst_flush", {31'd0, dut.OR_Flush.or_o}, 32'd0);
        chk("rst_memwb_rw", {31'd0, dut.memwb_rw}, 32'd0);
        #1;
        run(14);
        chk("pc0", pcs[0], 32'd0);
        chk("pc1", pcs[1], 32'd4);
        chk("pc2", pcs[2], 32'd8);
        chk("pc3", pcs[3], 32'd12);
        chk("alu_r11", reg_of(11), 32'hFFFF_FFE0);
        chk("alu_stalls", stalls, 32'd0);
        chk("alu_flushes", flushes, 32'd0);

        // Load-use.
        begin_test();
        dut.Data_Memory.memory[0] = 8'd5;
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_r(5'd8, 5'd8, 5'd9, 6'h20);
        dut.Instruction_Memory.memory[2] = enc_i(6'h2B, 5'd0, 5'd9, 16'd4);
        expect_wr(5'd8, 32'd5);
        expect_wr(5'd9, 32'd10);
        run(14);
        chk("lu_r9", reg_of(9), 32'd10);
        chk("lu_word4", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                         dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd10);
        chk("lu_stalls", stalls, 32'd1);

        // Taken branch.
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd2);
        expect_wr(5'd9, 32'd2);
        run(14);
        chk("br_r8", reg_of(8), 32'd0);
        chk("br_r9", reg_of(9), 32'd2);
        chk("br_flushes", flushes, 32'd1);
        chk("br_stalls", stalls, 32'd0);

        // Jump to word 4.
        begin_test();
        dut.Instruction_Memory.memory[0] = {6'h02, 26'd4};
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        dut.Instruction_Memory.memory[4] = enc_i(6'h08, 5'd0, 5'd9, 16'd2);
        expect_wr(5'd9, 32'd2);
        run(14);
        chk("j_pc0", pcs[0], 32'd0);
        chk("j_pc1", pcs[1], 32'd4);
        chk("j_pc2", pcs[2], 32'd16);
        chk("j_r8", reg_of(8), 32'd0);
        chk("j_flushes", flushes, 32'd1);

        // Register 0 is never written and reads 0 through forwarding.
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        expect_wr(5'd8, 32'd1);
        run(14);
        chk("r0_zero", reg_of(0), 32'd0);
        chk("r0_r8", reg_of(8), 32'd1);

        // beq depending on the previous result, untaken then taken.
        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd3);
        dut.Instruction_Memory.memory[1] = enc_i(6'h04, 5'd8, 5'd0, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd4);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd10, 16'd6);
        expect_wr(5'd8, 32'd3);
        expect_wr(5'd9, 32'd4);
        expect_wr(5'd10, 32'd6);
        run(14);
        chk("bnt_stalls", stalls, 32'd1);
        chk("bnt_flushes", flushes, 32'd0);

        begin_test();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd3);
        dut.Instruction_Memory.memory[1] = enc_i(6'h04, 5'd8, 5'd8, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd4);
        dut.Instruction_Memory.memory[3] = enc_i(6'h08, 5'd0, 5'd10, 16'd6);
        expect_wr(5'd8, 32'd3);
        expect_wr(5'd10, 32'd6);
        run(14);
        chk("bt_r9", reg_of(9), 32'd0);
        chk("bt_stalls", stalls, 32'd1);
        chk("bt_flushes", flushes, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
